// File: rtl/layer_compositor_pkg.sv
// ----------------------------------------------------------------------------
// layer_compositor_pkg
//   Shared VGA-path definitions for the sprite compositor:
//   - RGB_W        : pixel width ({R,G,B} 4 bits each)
//   - KEY_RGB_DEF  : default transparent colour key
//   - BG_RGB_DEF   : default background colour
//   - LYR_*        : layer index constants (index 0 = highest priority)
//   - blend_avg()  : per-channel 50/50 average used by the blend build
// ----------------------------------------------------------------------------
package layer_compositor_pkg;

   localparam int RGB_W = 12;

   typedef logic [RGB_W-1:0] rgb_t;

   localparam rgb_t KEY_RGB_DEF = 12'h0F0;
   localparam rgb_t BG_RGB_DEF  = 12'h69C;

   localparam int LYR_BOMBERMAN = 0;
   localparam int LYR_EXPLOSION = 1;
   localparam int LYR_BOMB      = 2;
   localparam int LYR_ENEMY     = 3;
   localparam int LYR_BOX       = 4;
   localparam int LYR_WALL      = 5;

   // Average each 4-bit channel through a 5-bit sum; the shift truncates.
   function automatic rgb_t blend_avg(input rgb_t a, input rgb_t b);
      rgb_t       res;
      logic [4:0] sum;
      res = 12'h000;
      for (int c = 0; c < 3; c++) begin
         sum = {1'b0, a[4*c +: 4]} + {1'b0, b[4*c +: 4]};
         res[4*c +: 4] = sum[4:1];
      end
      return res;
   endfunction

endpackage

// File: rtl/layer_compositor_prio_pick.sv
// ----------------------------------------------------------------------------
// layer_compositor_prio_pick
//   Combinational lowest-index-set finder. Returns the index of the lowest
//   set request bit (first) and of the next set bit above it (second), each
//   with a found flag. Indices are 0 when the matching flag is low.
// Ports
//   req          in   N        request vector
//   first_idx    out  IDX_W    lowest set index
//   first_found  out  1        at least one bit set
//   second_idx   out  IDX_W    second-lowest set index
//   second_found out  1        at least two bits set
// ----------------------------------------------------------------------------
module layer_compositor_prio_pick #(
   parameter int N     = 6,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   output logic [IDX_W-1:0] first_idx,
   output logic             first_found,
   output logic [IDX_W-1:0] second_idx,
   output logic             second_found
);

   // Ascending scan: the first hit claims "first", the next claims "second".
   always_comb begin
      first_idx    = {IDX_W{1'b0}};
      first_found  = 1'b0;
      second_idx   = {IDX_W{1'b0}};
      second_found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (req[i] && !first_found) begin
            first_idx   = IDX_W'(i);
            first_found = 1'b1;
         end else if (req[i] && !second_found) begin
            second_idx   = IDX_W'(i);
            second_found = 1'b1;
         end else begin
            second_found = second_found;
         end
      end
   end

endmodule

// File: rtl/layer_compositor.sv
// ----------------------------------------------------------------------------
// layer_compositor
//   Merges N_LAYERS sprite layers into one 12-bit VGA pixel by strict index
//   priority (0 = top) with a transparent colour key, over a fixed 2-cycle
//   pipeline. Also accumulates per-frame overlap flags between PLAYER_LAYER
//   and every other layer.
// Build option
//   COMPOSITOR_BLEND_EN : when defined, a top layer flagged in TRANSLUCENT is
//                         averaged with the next visible layer (or BG_RGB).
// Ports
//   sys_clk      in   1             pixel clock
//   Reset        in   1             asynchronous, active-high
//   bright       in   1             active-video flag
//   frame_start  in   1             pulse on first pixel of each frame
//   layer_en     in   N_LAYERS      per-layer enable for the current pixel
//   layer_rgb    in   12*N_LAYERS   per-layer colour, layer i at [12*i +: 12]
//   vga_rgb      out  12            composited pixel, registered
//   vga_valid    out  1             bright delayed 2 cycles
//   hit_frame    out  N_LAYERS      overlap flags of the previous frame
//   hit_any      out  1             OR of hit_frame without the player bit
// ----------------------------------------------------------------------------
module layer_compositor import layer_compositor_pkg::*; #(
   parameter int                  N_LAYERS     = 6,
   parameter int                  PLAYER_LAYER = LYR_BOMBERMAN,
   parameter logic [RGB_W-1:0]    KEY_RGB      = KEY_RGB_DEF,
   parameter logic [RGB_W-1:0]    BG_RGB       = BG_RGB_DEF,
   parameter logic [N_LAYERS-1:0] TRANSLUCENT  = {N_LAYERS{1'b0}}
) (
   input  logic                      sys_clk,
   input  logic                      Reset,
   input  logic                      bright,
   input  logic                      frame_start,
   input  logic [N_LAYERS-1:0]       layer_en,
   input  logic [RGB_W*N_LAYERS-1:0] layer_rgb,
   output logic [RGB_W-1:0]          vga_rgb,
   output logic                      vga_valid,
   output logic [N_LAYERS-1:0]       hit_frame,
   output logic                      hit_any
);

   localparam int IDX_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;

   logic [N_LAYERS-1:0] vis_s;
   logic [IDX_W-1:0]    first_idx_s, second_idx_s;
   logic                first_found_s, second_found_s;
   logic [RGB_W-1:0]    top_rgb_s, pix_s;

   logic                s1_bright_r, s1_fs_r, s1_found_r;
   logic [N_LAYERS-1:0] s1_vis_r;
   logic [RGB_W-1:0]    s1_top_rgb_r;

   logic [N_LAYERS-1:0] hit_now_s, hit_pub_s, hit_oth_s, hit_acc_r;
   logic [RGB_W-1:0]    vga_rgb_r;
   logic                vga_valid_r, hit_any_r;
   logic [N_LAYERS-1:0] hit_frame_r;

   // A layer is visible when enabled and not showing the colour key.
   always_comb begin
      vis_s = {N_LAYERS{1'b0}};
      for (int i = 0; i < N_LAYERS; i++) begin
         vis_s[i] = layer_en[i] && (layer_rgb[RGB_W*i +: RGB_W] != KEY_RGB);
      end
   end

   layer_compositor_prio_pick #(.N(N_LAYERS), .IDX_W(IDX_W)) u_prio_pick (
      .req          (vis_s),
      .first_idx    (first_idx_s),
      .first_found  (first_found_s),
      .second_idx   (second_idx_s),
      .second_found (second_found_s)
   );

   // Mux the top layer colour by its index.
   always_comb begin
      top_rgb_s = 12'h000;
      for (int i = 0; i < N_LAYERS; i++) begin
         top_rgb_s = (first_idx_s == IDX_W'(i)) ? layer_rgb[RGB_W*i +: RGB_W] : top_rgb_s;
      end
   end

   // Stage 1 register: sync flags, visible vector, top colour.
   always_ff @(posedge sys_clk or posedge Reset) begin
      if (Reset) begin
         s1_bright_r  <= 1'b0;
         s1_fs_r      <= 1'b0;
         s1_found_r   <= 1'b0;
         s1_vis_r     <= {N_LAYERS{1'b0}};
         s1_top_rgb_r <= 12'h000;
      end else begin
         s1_bright_r  <= bright;
         s1_fs_r      <= frame_start;
         s1_found_r   <= first_found_s;
         s1_vis_r     <= vis_s;
         s1_top_rgb_r <= top_rgb_s;
      end
   end

`ifdef COMPOSITOR_BLEND_EN
   logic [RGB_W-1:0] under_rgb_s, s1_under_rgb_r;
   logic             top_trans_s, s1_under_found_r, s1_top_trans_r;

   // Mux the under colour and the top layer's translucency bit.
   always_comb begin
      under_rgb_s = 12'h000;
      top_trans_s = 1'b0;
      for (int i = 0; i < N_LAYERS; i++) begin
         under_rgb_s = (second_idx_s == IDX_W'(i)) ? layer_rgb[RGB_W*i +: RGB_W] : under_rgb_s;
         top_trans_s = (first_idx_s == IDX_W'(i)) ? TRANSLUCENT[i] : top_trans_s;
      end
   end

   // Stage 1 extension for the blend path.
   always_ff @(posedge sys_clk or posedge Reset) begin
      if (Reset) begin
         s1_under_rgb_r   <= 12'h000;
         s1_under_found_r <= 1'b0;
         s1_top_trans_r   <= 1'b0;
      end else begin
         s1_under_rgb_r   <= under_rgb_s;
         s1_under_found_r <= second_found_s;
         s1_top_trans_r   <= top_trans_s;
      end
   end

   // Stage 2 colour: blank, background, top, or top averaged with what lies beneath.
   always_comb begin
      pix_s = 12'h000;
      if (!s1_bright_r) begin
         pix_s = 12'h000;
      end else if (!s1_found_r) begin
         pix_s = BG_RGB;
      end else if (s1_top_trans_r) begin
         pix_s = blend_avg(s1_top_rgb_r, s1_under_found_r ? s1_under_rgb_r : BG_RGB);
      end else begin
         pix_s = s1_top_rgb_r;
      end
   end
`else
   logic unused_blend_s;
   assign unused_blend_s = ^{second_idx_s, second_found_s, TRANSLUCENT};

   // Stage 2 colour: blank, background, or top.
   always_comb begin
      pix_s = 12'h000;
      if (!s1_bright_r) begin
         pix_s = 12'h000;
      end else if (!s1_found_r) begin
         pix_s = BG_RGB;
      end else begin
         pix_s = s1_top_rgb_r;
      end
   end
`endif

   // Overlap contribution of the stage-1 pixel; the player bit sets itself.
   always_comb begin
      hit_now_s = {N_LAYERS{1'b0}};
      if (s1_bright_r && s1_vis_r[PLAYER_LAYER]) begin
         hit_now_s = s1_vis_r;
      end else begin
         hit_now_s = {N_LAYERS{1'b0}};
      end
      hit_pub_s = hit_acc_r | hit_now_s;
      hit_oth_s = hit_pub_s;
      hit_oth_s[PLAYER_LAYER] = 1'b0;
   end

   // Stage 2 register: output pixel and the per-frame collision accumulator.
   always_ff @(posedge sys_clk or posedge Reset) begin
      if (Reset) begin
         vga_rgb_r   <= 12'h000;
         vga_valid_r <= 1'b0;
         hit_acc_r   <= {N_LAYERS{1'b0}};
         hit_frame_r <= {N_LAYERS{1'b0}};
         hit_any_r   <= 1'b0;
      end else begin
         vga_rgb_r   <= pix_s;
         vga_valid_r <= s1_bright_r;
         if (s1_fs_r) begin
            hit_frame_r <= hit_pub_s;
            hit_any_r   <= |hit_oth_s;
            hit_acc_r   <= {N_LAYERS{1'b0}};
         end else begin
            hit_acc_r   <= hit_pub_s;
         end
      end
   end

   assign vga_rgb   = vga_rgb_r;
   assign vga_valid = vga_valid_r;
   assign hit_frame = hit_frame_r;
   assign hit_any   = hit_any_r;

endmodule

// File: tb/tb_layer_compositor.sv
// ----------------------------------------------------------------------------
// tb_layer_compositor
//   Directed stimulus for layer_compositor (default build) with a
//   priority/colour-key model checked on every falling edge, plus literal
//   expectations at the points of interest.
// ----------------------------------------------------------------------------
module tb_layer_compositor;

   localparam int          N   = 6;
   localparam int          P   = 0;
   localparam logic [11:0] KEY = 12'h0F0;
   localparam logic [11:0] BG  = 12'h69C;
   localparam logic [N-1:0] PM = 6'b000001;

   logic            sys_clk = 1'b0;
   logic            Reset;
   logic            bright;
   logic            frame_start;
   logic [N-1:0]    layer_en;
   logic [12*N-1:0] layer_rgb;
   logic [11:0]     vga_rgb;
   logic            vga_valid;
   logic [N-1:0]    hit_frame;
   logic            hit_any;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 sys_clk = ~sys_clk;

   layer_compositor #(
      .N_LAYERS(N), .PLAYER_LAYER(P), .KEY_RGB(KEY), .BG_RGB(BG), .TRANSLUCENT(6'b000000)
   ) dut (
      .sys_clk(sys_clk), .Reset(Reset), .bright(bright), .frame_start(frame_start),
      .layer_en(layer_en), .layer_rgb(layer_rgb), .vga_rgb(vga_rgb),
      .vga_valid(vga_valid), .hit_frame(hit_frame), .hit_any(hit_any)
   );

   // ---------------- model ----------------
   function automatic logic [11:0] model_pix(input logic b, input logic [N-1:0] en,
                                             input logic [12*N-1:0] rgb);
      if (!b) return 12'h000;
      for (int i = 0; i < N; i++)
         if (en[i] && rgb[12*i +: 12] != KEY) return rgb[12*i +: 12];
      return BG;
   endfunction

   function automatic logic [N-1:0] model_hit(input logic b, input logic [N-1:0] en,
                                              input logic [12*N-1:0] rgb);
      logic [N-1:0] v;
      v = '0;
      if (!b || !en[P] || rgb[12*P +: 12] == KEY) return v;
      for (int i = 0; i < N; i++) v[i] = en[i] && rgb[12*i +: 12] != KEY;
      return v;
   endfunction

   logic [11:0]  m_rgb1, m_rgb2;
   logic         m_val1, m_val2, m_pub1, m_any2;
   logic [N-1:0] m_acc, m_pubval1, m_hit2;

   always @(posedge sys_clk or posedge Reset) begin
      if (Reset) begin
         m_rgb1 <= '0; m_rgb2 <= '0; m_val1 <= 1'b0; m_val2 <= 1'b0;
         m_pub1 <= 1'b0; m_pubval1 <= '0; m_acc <= '0; m_hit2 <= '0; m_any2 <= 1'b0;
      end else begin
         m_rgb1   <= model_pix(bright, layer_en, layer_rgb);
         m_val1   <= bright;
         m_rgb2   <= m_rgb1;
         m_val2   <= m_val1;
         m_pub1   <= frame_start;
         m_pubval1 <= m_acc | model_hit(bright, layer_en, layer_rgb);
         m_acc    <= frame_start ? '0 : (m_acc | model_hit(bright, layer_en, layer_rgb));
         if (m_pub1) begin
            m_hit2 <= m_pubval1;
            m_any2 <= |(m_pubval1 & ~PM);
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // Continuous comparison against the model away from the active edge.
   always @(negedge sys_clk) begin
      check("model_rgb",   32'(vga_rgb),   32'(m_rgb2));
      check("model_valid", 32'(vga_valid), 32'(m_val2));
      check("model_hit",   32'(hit_frame), 32'(m_hit2));
      check("model_any",   32'(hit_any),   32'(m_any2));
   end

   // ---------------- stimulus ----------------
   function automatic logic [12*N-1:0] mk(input logic [11:0] c0, c1, c2, c3, c4, c5);
      return {c5, c4, c3, c2, c1, c0};
   endfunction

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic px(input logic b, input logic fs, input logic [N-1:0] en,
                     input logic [12*N-1:0] rgb);
      bright = b; frame_start = fs; layer_en = en; layer_rgb = rgb;
      tick();
   endtask

   task automatic idle();
      px(1'b0, 1'b0, 6'b000000, mk(12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000));
   endtask

   initial begin
      Reset = 1'b0; bright = 1'b0; frame_start = 1'b0; layer_en = '0; layer_rgb = '0;
      #1 Reset = 1'b1;
      // frame_start while in reset must be ignored
      frame_start = 1'b1; layer_en = 6'b000011; bright = 1'b1;
      layer_rgb = mk(12'h00F, 12'hF00, 12'h000, 12'h000, 12'h000, 12'h000);
      tick(); tick();
      check("reset_rgb",   32'(vga_rgb),   32'h000);
      check("reset_valid", 32'(vga_valid), 32'h0);
      check("reset_hit",   32'(hit_frame), 32'h00);
      check("reset_any",   32'(hit_any),   32'h0);
      idle();
      Reset = 1'b0;
      idle(); idle();

      // 1: single layer 3, exact 2-cycle latency
      px(1'b1, 1'b0, 6'b001000, mk(12'h000, 12'h000, 12'h000, 12'hF00, 12'h000, 12'h000));
      check("t1_lat1_rgb", 32'(vga_rgb), 32'h000);
      idle();
      check("t1_rgb",   32'(vga_rgb),   32'hF00);
      check("t1_valid", 32'(vga_valid), 32'h1);

      // 2: priority, then colour key on the top layer
      px(1'b1, 1'b0, 6'b010001, mk(12'h00F, 12'h000, 12'h000, 12'h000, 12'hFFF, 12'h000));
      px(1'b1, 1'b0, 6'b010001, mk(KEY,     12'h000, 12'h000, 12'h000, 12'hFFF, 12'h000));
      check("t2_prio", 32'(vga_rgb), 32'h00F);
      idle();
      check("t2_key", 32'(vga_rgb), 32'hFFF);

      // 3: background, and blanking with layers enabled
      px(1'b1, 1'b0, 6'b000000, mk(12'hF00, 12'hF00, 12'hF00, 12'hF00, 12'hF00, 12'hF00));
      px(1'b0, 1'b0, 6'b111111, mk(12'h123, 12'h123, 12'h123, 12'h123, 12'h123, 12'h123));
      check("t3_bg", 32'(vga_rgb), 32'h69C);
      idle();
      check("t3_blank_rgb",   32'(vga_rgb),   32'h000);
      check("t3_blank_valid", 32'(vga_valid), 32'h0);

      // 4: frame 1 with a one-pixel overlap, clean frame 2
      px(1'b0, 1'b1, 6'b000000, '0);
      idle(); idle();
      px(1'b1, 1'b0, 6'b000011, mk(12'h00F, 12'hF00, 12'h000, 12'h000, 12'h000, 12'h000));
      px(1'b1, 1'b0, 6'b000100, mk(12'h00F, 12'hF00, 12'hABC, 12'h000, 12'h000, 12'h000));
      px(1'b0, 1'b1, 6'b000000, '0);
      idle();
      check("t4_f1_hit", 32'(hit_frame), 32'h03);
      check("t4_f1_any", 32'(hit_any),   32'h1);
      px(1'b0, 1'b0, 6'b000011, mk(12'h00F, 12'hF00, 12'h000, 12'h000, 12'h000, 12'h000));
      px(1'b0, 1'b1, 6'b000000, '0);
      idle();
      check("t4_f2_hit", 32'(hit_frame), 32'h00);
      check("t4_f2_any", 32'(hit_any),   32'h0);
      // player alone: self bit only
      px(1'b1, 1'b0, 6'b000001, mk(12'h00F, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000));
      px(1'b0, 1'b1, 6'b000000, '0);
      idle();
      check("t4_self_hit", 32'(hit_frame), 32'h01);
      check("t4_self_any", 32'(hit_any),   32'h0);

      // 5: overlap coincident with frame_start
      px(1'b1, 1'b1, 6'b100001, mk(12'h00F, 12'h000, 12'h000, 12'h000, 12'h000, 12'hABC));
      idle();
      check("t5_coinc_hit", 32'(hit_frame), 32'h21);
      check("t5_coinc_any", 32'(hit_any),   32'h1);
      // reset mid-frame after an overlap
      px(1'b1, 1'b0, 6'b000101, mk(12'h00F, 12'h000, 12'hABC, 12'h000, 12'h000, 12'h000));
      px(1'b1, 1'b0, 6'b000101, mk(12'h00F, 12'h000, 12'hABC, 12'h000, 12'h000, 12'h000));
      #2 Reset = 1'b1;
      #1;
      check("t5_rst_rgb",   32'(vga_rgb),   32'h000);
      check("t5_rst_valid", 32'(vga_valid), 32'h0);
      check("t5_rst_hit",   32'(hit_frame), 32'h00);
      check("t5_rst_any",   32'(hit_any),   32'h0);
      idle(); idle();
      Reset = 1'b0;
      px(1'b0, 1'b1, 6'b000000, '0);
      idle();
      check("t5_acc_clr", 32'(hit_frame), 32'h00);

      // back-to-back frame_start pulses and a deep-layer pixel
      px(1'b1, 1'b0, 6'b000011, mk(12'h00F, 12'hF00, 12'h000, 12'h000, 12'h000, 12'h000));
      px(1'b0, 1'b1, 6'b000000, '0);
      px(1'b0, 1'b1, 6'b000000, '0);
      check("b2b_first", 32'(hit_frame), 32'h03);
      idle();
      check("b2b_second", 32'(hit_frame), 32'h00);
      px(1'b1, 1'b0, 6'b111110, mk(12'h00F, KEY, KEY, KEY, KEY, 12'h5A5));
      idle();
      check("deep_layer", 32'(vga_rgb), 32'h5A5);
      idle(); idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
